rv_lsu: RTL

- Load/store unit sitting directly upstream of the 64-bit data memory wrapper; consumes memory requests from the EX/MEM stage.
- Turns RV64 byte-addressed LB/LH/LW/LD/LBU/LHU/LWU/SB/SH/SW/SD into doubleword-indexed memory accesses.
- The memory has no byte enables, so sub-doubleword stores use a read-modify-write sequence.
- Performs sign/zero extension of loads and flags misaligned or illegal accesses.

---
 rtl/rv_lsu_pkg.sv | 31 +++
 rtl/rv_lsu_align.sv | 38 +++
 rtl/rv_lsu.sv | 119 +++++++++++
 3 files changed

// File: rtl/rv_lsu_pkg.sv
// Shared types and helpers for the RV64 load/store unit.
// funct3 encodings, FSM state encoding and the access-size mask.
package rv_lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_CAP  = 3'd2,
    S_WR   = 3'd3,
    S_RESP = 3'd4
  } lsu_state_e;

  // funct3[1:0] encodes log2 of the access size in bytes
  function automatic logic [63:0] size_mask(input logic [1:0] sz);
    case (sz)
      2'd0:    return 64'h0000_0000_0000_00FF;
      2'd1:    return 64'h0000_0000_0000_FFFF;
      2'd2:    return 64'h0000_0000_FFFF_FFFF;
      default: return 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
  endfunction

endpackage

// File: rtl/rv_lsu_align.sv
// Byte-lane datapath: load extract/extend and read-modify-write store merge
// for one doubleword, driven by funct3 and the byte offset within it.
module rv_lsu_align
  import rv_lsu_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [2:0]      funct3,
  input  logic [2:0]      off,
  input  logic [XLEN-1:0] old_data,
  input  logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] ld_data,
  output logic [XLEN-1:0] st_data
);

  logic [5:0]      sh;
  logic [XLEN-1:0] mask;
  logic [XLEN-1:0] lane;
  logic [XLEN-1:0] wd_sh;

  always_comb begin
    sh      = {off, 3'b000};
    mask    = size_mask(funct3[1:0]) << sh;
    lane    = old_data >> sh;
    wd_sh   = wdata << sh;
    st_data = (old_data & ~mask) | (wd_sh & mask);
    case (funct3)
      F3_B:    ld_data = {{(XLEN-8){lane[7]}},   lane[7:0]};
      F3_H:    ld_data = {{(XLEN-16){lane[15]}}, lane[15:0]};
      F3_W:    ld_data = {{(XLEN-32){lane[31]}}, lane[31:0]};
      F3_BU:   ld_data = {{(XLEN-8){1'b0}},      lane[7:0]};
      F3_HU:   ld_data = {{(XLEN-16){1'b0}},     lane[15:0]};
      F3_WU:   ld_data = {{(XLEN-32){1'b0}},     lane[31:0]};
      default: ld_data = lane;
    endcase
  end

endmodule

// File: rtl/rv_lsu.sv
// RV64 load/store unit in front of a 64-bit memory without byte enables.
// Sub-doubleword stores go through read-modify-write; errors answer in one cycle.
module rv_lsu
  import rv_lsu_pkg::*;
#(
  parameter int ADDR_WID = 12,
  parameter int XLEN     = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic            req_we_i,
  input  logic [2:0]      req_funct3_i,
  input  logic [XLEN-1:0] req_addr_i,
  input  logic [XLEN-1:0] req_wdata_i,
  output logic            rsp_valid_o,
  output logic [XLEN-1:0] rsp_rdata_o,
  output logic            rsp_err_o,
  output logic [XLEN-1:0] mem_addr_o,
  output logic            mem_wr_en_o,
  output logic [XLEN-1:0] mem_wr_data_o,
  output logic            mem_rd_en_o,
  input  logic [XLEN-1:0] mem_rd_data_i
);

  lsu_state_e      state_q, state_d;
  logic            we_q, we_d;
  logic [2:0]      f3_q, f3_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] data_q, data_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic            err_q, err_d;
  logic [XLEN-1:0] ld_data, st_data;
  logic            mis, ill;

  rv_lsu_align #(.XLEN(XLEN)) u_align (
    .funct3   (f3_q),
    .off      (addr_q[2:0]),
    .old_data (mem_rd_data_i),
    .wdata    (data_q),
    .ld_data  (ld_data),
    .st_data  (st_data)
  );

  always_comb begin
    case (req_funct3_i[1:0])
      2'd1:    mis = req_addr_i[0];
      2'd2:    mis = |req_addr_i[1:0];
      2'd3:    mis = |req_addr_i[2:0];
      default: mis = 1'b0;
    endcase
    ill = req_we_i ? req_funct3_i[2] : (req_funct3_i == 3'b111);
  end

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    f3_d    = f3_q;
    addr_d  = addr_q;
    data_d  = data_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: if (req_valid_i) begin
        we_d    = req_we_i;
        f3_d    = req_funct3_i;
        addr_d  = req_addr_i;
        data_d  = req_wdata_i;
        rdata_d = '0;
        err_d   = mis | ill;
        // a full doubleword store needs no old data, so it skips the read
        if (mis | ill)                                  state_d = S_RESP;
        else if (req_we_i && req_funct3_i[1:0] == 2'd3) state_d = S_WR;
        else                                            state_d = S_RD;
      end
      S_RD:  state_d = S_CAP;
      S_CAP: if (we_q) begin
        data_d  = st_data;
        state_d = S_WR;
      end else begin
        rdata_d = ld_data;
        state_d = S_RESP;
      end
      S_WR:    state_d = S_RESP;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign req_ready_o   = (state_q == S_IDLE);
  assign mem_rd_en_o   = (state_q == S_RD);
  assign mem_wr_en_o   = (state_q == S_WR);
  assign mem_wr_data_o = data_q;
  assign mem_addr_o    = {{(XLEN-ADDR_WID){1'b0}}, addr_q[ADDR_WID+2:3]};
  assign rsp_valid_o   = (state_q == S_RESP);
  assign rsp_rdata_o   = rsp_valid_o ? rdata_q : '0;
  assign rsp_err_o     = rsp_valid_o & err_q;

endmodule
